// File: rtl/noise_inject_pipe.sv
// -----------------------------------------------------------------------------
// noise_inject_pipe
//
// Noise-injection stage for the SERDES channel model. Each accepted input
// symbol has a noise sample added to it. The sample comes from a noise table
// that is loaded at run time and indexed by a free-running LFSR. The sum
// saturates to the DATA_W signed range. The stage sits between the
// channel/ISI model and the receiver/DFE input.
//
// Optional feature (compile-time macro NOISE_INJECT_STATS_EN):
//   adds stat_samples / stat_sat output-handshake counters. The datapath is
//   identical with or without the macro.
//
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   load_mem        1 = force table-load mode (LOAD state, pipeline flushed)
//   tbl_we          table write strobe, honoured only in LOAD
//   tbl_addr        table write address
//   tbl_wdata       signed table write data
//   noise_en        0 = bypass (noise term forced to zero)
//   noise_shift     arithmetic right shift applied to the noise sample
//   in_data         signed input symbol      (in_valid / in_ready)
//   out_data        signed noisy symbol      (out_valid / out_ready)
//   done_wait       1 = RUN state (table loaded, warm-up complete)
//   dbg_state       current FSM state, for checkers
//   stat_samples    output handshakes since reset/LOAD   (macro only)
//   stat_sat        saturated output handshakes          (macro only)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. out_valid/out_data never change while out_valid=1 and out_ready=0.
// in_ready does not depend on in_valid.
// -----------------------------------------------------------------------------
module noise_inject_pipe #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NOISE_W   = 8,
    parameter int unsigned TBL_AW    = 7,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned WARM_CYC  = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               load_mem,
    input  logic               tbl_we,
    input  logic [TBL_AW-1:0]  tbl_addr,
    input  logic [NOISE_W-1:0] tbl_wdata,
    input  logic               noise_en,
    input  logic [2:0]         noise_shift,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               done_wait,
    output logic [1:0]         dbg_state
`ifdef NOISE_INJECT_STATS_EN
    ,
    output logic [31:0]        stat_samples,
    output logic [31:0]        stat_sat
`endif
);

    localparam int unsigned SUM_W     = ((DATA_W > NOISE_W) ? DATA_W : NOISE_W) + 1;
    localparam int unsigned DEPTH     = 1 << TBL_AW;
    localparam logic [15:0] WARM_LAST = 16'(WARM_CYC - 1);
    localparam logic [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d, lfsr_step;
    logic [15:0]         warm_cnt_q, warm_cnt_d;
    logic                s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]   s1_data_q, s1_data_d;
    logic [SUM_W-1:0]    s1_noise_q, s1_noise_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic                pipe_en;
    logic                accept;
    logic [NOISE_W-1:0]  noise_raw;
    logic signed [NOISE_W-1:0] noise_shifted;
    logic [SUM_W-1:0]    noise_term;
    logic [SUM_W-1:0]    sum;
    logic                sat_hi, sat_lo;
    logic [DATA_W-1:0]   sat_data;

    // Noise table: no reset, contents survive re-entry into LOAD.
    logic [NOISE_W-1:0]  tbl_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (tbl_we && (state_q == ST_LOAD)) begin
            tbl_mem[tbl_addr] <= tbl_wdata;
        end
    end

    assign pipe_en   = !out_valid_q || out_ready;
    assign in_ready  = (state_q == ST_RUN) && pipe_en;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done_wait = (state_q == ST_RUN);
    assign dbg_state = state_q;

    // 16-bit Galois LFSR, right shift, taps 16'hB400.
    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // Noise term is fixed at S1 capture, so noise_en/noise_shift changes only
    // affect samples accepted afterwards.
    assign noise_raw     = tbl_mem[lfsr_q[TBL_AW-1:0]];
    assign noise_shifted = $signed(noise_raw) >>> noise_shift;
    assign noise_term    = noise_en ? {{(SUM_W-NOISE_W){noise_shifted[NOISE_W-1]}}, noise_shifted}
                                    : '0;

    // One guard bit above the wider operand, so the sum cannot wrap. The sum
    // is out of range when the bits above the DATA_W sign bit disagree with
    // the true sign.
    assign sum    = {{(SUM_W-DATA_W){s1_data_q[DATA_W-1]}}, s1_data_q} + s1_noise_q;
    assign sat_hi = !sum[SUM_W-1] && (sum[SUM_W-2:DATA_W-1] != '0);
    assign sat_lo =  sum[SUM_W-1] && (sum[SUM_W-2:DATA_W-1] != '1);
    assign sat_data = sat_hi ? DATA_MAX : (sat_lo ? DATA_MIN : sum[DATA_W-1:0]);

    // FSM and LFSR next state. load_mem has priority over everything.
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        lfsr_d     = lfsr_q;
        if (load_mem) begin
            state_d    = ST_LOAD;
            warm_cnt_d = '0;
            lfsr_d     = LFSR_SEED;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    state_d    = ST_WARM;
                    warm_cnt_d = '0;
                    lfsr_d     = LFSR_SEED;
                end
                ST_WARM: begin
                    lfsr_d = lfsr_step;
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d    = ST_RUN;
                        warm_cnt_d = '0;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 16'd1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        lfsr_d = lfsr_step;
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    // Two-stage pipeline with one global advance enable. A load request drops
    // whatever is in flight.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_noise_d  = s1_noise_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load_mem) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else if (pipe_en) begin
            s1_valid_d  = accept;
            if (accept) begin
                s1_data_d  = in_data;
                s1_noise_d = noise_term;
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = sat_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_LOAD;
            lfsr_q      <= LFSR_SEED;
            warm_cnt_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_noise_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            warm_cnt_q  <= warm_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_noise_q  <= s1_noise_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef NOISE_INJECT_STATS_EN
    // Saturation flag travels with out_data so it can be counted at the
    // output handshake.
    logic        out_sat_q, out_sat_d;
    logic [31:0] stat_samples_q, stat_samples_d;
    logic [31:0] stat_sat_q, stat_sat_d;

    always_comb begin
        out_sat_d      = out_sat_q;
        stat_samples_d = stat_samples_q;
        stat_sat_d     = stat_sat_q;
        if (load_mem) begin
            out_sat_d      = 1'b0;
            stat_samples_d = '0;
            stat_sat_d     = '0;
        end else begin
            if (pipe_en && s1_valid_q) begin
                out_sat_d = sat_hi || sat_lo;
            end
            if (out_valid_q && out_ready) begin
                stat_samples_d = stat_samples_q + 32'd1;
                if (out_sat_q) begin
                    stat_sat_d = stat_sat_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_sat_q      <= 1'b0;
            stat_samples_q <= '0;
            stat_sat_q     <= '0;
        end else begin
            out_sat_q      <= out_sat_d;
            stat_samples_q <= stat_samples_d;
            stat_sat_q     <= stat_sat_d;
        end
    end

    assign stat_samples = stat_samples_q;
    assign stat_sat     = stat_sat_q;
`endif

endmodule

// File: tb/tb_noise_inject_pipe.sv
// -----------------------------------------------------------------------------
// tb_noise_inject_pipe
//
// Bench for noise_inject_pipe with default parameters. The stimulus driver
// pushes the expected output of each accepted symbol into exp_q. A separate
// monitor pops exp_q on every output handshake and compares. Expected values
// come from the table contents the bench wrote, an LFSR sequence model and
// plain integer add/clamp arithmetic.
// -----------------------------------------------------------------------------
module tb_noise_inject_pipe;

    localparam int          DEPTH = 128;
    localparam int          WARM  = 16;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic       clk = 1'b0;
    logic       rstn;
    logic       load_mem;
    logic       tbl_we;
    logic [6:0] tbl_addr;
    logic [7:0] tbl_wdata;
    logic       noise_en;
    logic [2:0] noise_shift;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       done_wait;
    logic [1:0] dbg_state;
`ifdef NOISE_INJECT_STATS_EN
    logic [31:0] stat_samples;
    logic [31:0] stat_sat;
`endif

    noise_inject_pipe dut (
        .clk         (clk),
        .rstn        (rstn),
        .load_mem    (load_mem),
        .tbl_we      (tbl_we),
        .tbl_addr    (tbl_addr),
        .tbl_wdata   (tbl_wdata),
        .noise_en    (noise_en),
        .noise_shift (noise_shift),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .done_wait   (done_wait),
        .dbg_state   (dbg_state)
`ifdef NOISE_INJECT_STATS_EN
        ,
        .stat_samples(stat_samples),
        .stat_sat    (stat_sat)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping / model ----------------
    int         checks   = 0;
    int         failures = 0;
    int         tbl_m [DEPTH];
    logic [15:0] lfsr_m;
    logic [7:0] exp_q[$];
    bit         exp_sat_q[$];
    int         mdl_samples = 0;
    int         mdl_sat     = 0;
    bit         or_force0   = 1'b0;
    bit         or_rand     = 1'b0;

    task automatic report(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // ---------------- downstream ready driver ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (or_force0)    out_ready = 1'b0;
            else if (or_rand) out_ready = ($urandom_range(0, 3) != 0);
            else              out_ready = 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        bit         prev_stall = 1'b0;
        bit         prev_load  = 1'b0;
        logic [7:0] prev_data  = '0;
        logic [7:0] e;
        bit         es;
        forever begin
            @(negedge clk);
            #2;
            if (rstn) begin
                if (prev_stall && !prev_load) begin
                    report(out_valid === 1'b1, "stall_valid_hold", int'(out_valid), 1);
                    report(out_data === prev_data, "stall_data_hold",
                           int'($signed(out_data)), int'($signed(prev_data)));
                end
                if (out_valid && !out_ready) begin
                    report(in_ready === 1'b0, "stall_in_ready", int'(in_ready), 0);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        report(1'b0, "unexpected_output", int'($signed(out_data)), 0);
                    end else begin
                        e  = exp_q.pop_front();
                        es = exp_sat_q.pop_front();
                        report(out_data === e, "out_data", int'($signed(out_data)), int'($signed(e)));
                        mdl_samples++;
                        if (es) mdl_sat++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_load  = load_mem;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input int d, input bit en, input int sh, input int gap);
        int         guard;
        int         n;
        int         s;
        logic [7:0] ev;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid    = 1'b1;
        in_data     = 8'(d);
        noise_en    = en;
        noise_shift = 3'(sh);
        #1;
        guard = 0;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            report(1'b0, "accept_timeout", guard, 300);
        end else begin
            n = en ? (tbl_m[lfsr_m[6:0]] >>> sh) : 0;
            s = d + n;
            exp_sat_q.push_back((s > 127) || (s < -128));
            if (s > 127)  s = 127;
            if (s < -128) s = -128;
            ev = 8'(s);
            exp_q.push_back(ev);
            lfsr_m = lfsr_next(lfsr_m);
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
    endtask

    // mode 0: every entry = val; mode 1: random entries.
    task automatic load_table(input int mode, input int val, input bit chk_flush);
        int v;
        int cnt;
        @(negedge clk);
        load_mem = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        if (chk_flush) begin
            report(in_ready === 1'b0, "flush_in_ready", int'(in_ready), 0);
            report(done_wait === 1'b0, "flush_done_wait", int'(done_wait), 0);
            report(out_valid === 1'b0, "flush_out_valid", int'(out_valid), 0);
        end
        exp_q.delete();
        exp_sat_q.delete();
        mdl_samples = 0;
        mdl_sat     = 0;
        for (int i = 0; i < DEPTH; i++) begin
            v         = (mode == 1) ? ($urandom_range(0, 255) - 128) : val;
            tbl_m[i]  = v;
            tbl_we    = 1'b1;
            tbl_addr  = 7'(i);
            tbl_wdata = 8'(v);
            @(negedge clk);
        end
        tbl_we   = 1'b0;
        load_mem = 1'b0;
        cnt = 0;
        while (!done_wait && cnt < 100) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        report(cnt == WARM + 1, "warm_cycles", cnt, WARM + 1);
        lfsr_m = SEED;
        repeat (WARM) lfsr_m = lfsr_next(lfsr_m);
    endtask

    task automatic check_stats();
`ifdef NOISE_INJECT_STATS_EN
        @(negedge clk);
        #3;
        report(stat_samples == 32'(mdl_samples), "stat_samples", int'(stat_samples), mdl_samples);
        report(stat_sat == 32'(mdl_sat), "stat_sat", int'(stat_sat), mdl_sat);
`endif
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        report(exp_q.size() == 0, "drain", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        #3;
        report(out_valid === 1'b0, "no_extra_output", int'(out_valid), 0);
        check_stats();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        rstn        = 1'b0;
        load_mem    = 1'b1;
        tbl_we      = 1'b0;
        tbl_addr    = '0;
        tbl_wdata   = '0;
        noise_en    = 1'b1;
        noise_shift = '0;
        in_data     = '0;
        in_valid    = 1'b0;
        lfsr_m      = SEED;

        repeat (3) @(negedge clk);
        #1;
        report(out_valid === 1'b0, "reset_out_valid", int'(out_valid), 0);
        report(out_data === 8'h00, "reset_out_data", int'($signed(out_data)), 0);
        report(in_ready === 1'b0, "reset_in_ready", int'(in_ready), 0);
        report(done_wait === 1'b0, "reset_done_wait", int'(done_wait), 0);
        rstn = 1'b1;

        // Basic: all entries +3, shift 0, with a latency check on the first symbol.
        load_table(0, 3, 1'b0);
        send(10, 1'b1, 0, 0);
        #1;
        report(out_valid === 1'b0, "latency_early", int'(out_valid), 0);
        @(posedge clk);
        #1;
        report(out_valid === 1'b1, "latency_valid", int'(out_valid), 1);
        report(out_data === 8'd13, "latency_data", int'($signed(out_data)), 13);
        send(-5, 1'b1, 0, 0);
        send(0, 1'b1, 0, 0);
        drain();

        // Saturation in both directions.
        load_table(0, 20, 1'b0);
        send(120, 1'b1, 0, 0);
        send(100, 1'b1, 0, 0);
        send(-128, 1'b1, 0, 0);
        send(127, 1'b1, 0, 1);
        drain();
        load_table(0, -20, 1'b0);
        send(-120, 1'b1, 0, 0);
        send(-100, 1'b1, 0, 0);
        send(-128, 1'b1, 0, 0);
        drain();

        // Bypass and scaling.
        load_table(0, 16, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send($urandom_range(0, 255) - 128, 1'b1, 2, 0);
            send($urandom_range(0, 255) - 128, 1'b0, 2, 0);
        end
        drain();
        load_table(0, -1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send($urandom_range(0, 255) - 128, 1'b1, 3, $urandom_range(0, 1));
        end
        drain();

        // Random table, random controls, random back-pressure plus a 5-cycle stall.
        load_table(1, 0, 1'b0);
        or_rand = 1'b1;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send($urandom_range(0, 255) - 128, 1'($urandom_range(0, 1)),
                         $urandom_range(0, 7), $urandom_range(0, 2));
                end
            end
            begin
                repeat (40) @(negedge clk);
                or_force0 = 1'b1;
                repeat (5) @(negedge clk);
                or_force0 = 1'b0;
            end
        join
        or_rand = 1'b0;
        drain();

        // Load mid-stream: two symbols stuck in the pipe get dropped, new table applies.
        or_force0 = 1'b1;
        send(1, 1'b1, 0, 0);
        send(2, 1'b1, 0, 0);
        repeat (2) @(negedge clk);
        load_table(0, 5, 1'b1);
        or_force0 = 1'b0;
        send(7, 1'b1, 0, 0);
        send(-9, 1'b1, 0, 0);
        send(125, 1'b1, 0, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
